prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/sat_counter.sv | 17 +
 rtl/prbs_checker.sv | 136 +++++++++++++
 tb/tb_prbs_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS checker slice.
package prbs_pkg;

  localparam int PRBS_N_DEF   = 7;
  localparam int PRBS_TAP_DEF = 6;
  localparam int CNT_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Per-sample outcome handed to the statistics counters.
  typedef struct packed {
    logic bit_vld;
    logic err;
  } chk_evt_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         emu_clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge emu_clk) begin
    if (rst || clr)                    count <= '0;
    else if (inc && count != {W{1'b1}}) count <= count + W'(1);
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-seeding LFSR, lock/loss FSM and saturating error/bit statistics.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N          = PRBS_N_DEF,
  parameter int TAP        = PRBS_TAP_DEF,
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             emu_clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int SEED_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);

  state_t             state, state_nxt;
  logic [N-1:0]       lfsr, lfsr_nxt;
  logic [SEED_W-1:0]  seed_cnt, seed_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  chk_evt_t           evt;
  logic               pred;

  assign pred = lfsr[N-1] ^ lfsr[TAP-1];

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    evt       = '0;
    if (clk_en) begin
      case (state)
        ST_SEED: begin
          lfsr_nxt = {lfsr[N-2:0], in};
          if (seed_cnt == SEED_LAST) begin
            // An all-zero seed would predict zeros forever; keep seeding instead.
            seed_nxt = '0;
            if (lfsr_nxt != '0) begin
              state_nxt = ST_VERIFY;
              match_nxt = '0;
            end
          end else begin
            seed_nxt = seed_cnt + SEED_W'(1);
          end
        end
        ST_VERIFY: begin
          if (in == pred) begin
            lfsr_nxt = {lfsr[N-2:0], pred};
            if (match_cnt == MATCH_LAST) begin
              state_nxt = ST_LOCKED;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              match_nxt = match_cnt + MATCH_W'(1);
            end
          end else begin
            // The offending bit becomes the first bit of the new seed.
            state_nxt = ST_SEED;
            lfsr_nxt  = {lfsr[N-2:0], in};
            seed_nxt  = SEED_W'(1);
          end
        end
        ST_LOCKED: begin
          lfsr_nxt    = {lfsr[N-2:0], pred};
          evt.bit_vld = 1'b1;
          if (in != pred) begin
            evt.err = 1'b1;
            if (miss_cnt == MISS_LAST) begin
              state_nxt = ST_SEED;
              seed_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge emu_clk) begin
    if (rst) begin
      state     <= ST_SEED;
      lfsr      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err_pulse <= evt.err & ~clr;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .emu_clk (emu_clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (evt.err & ~clr),
    .count   (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .emu_clk (emu_clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (evt.bit_vld & ~clr),
    .count   (bit_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed and randomized bench for prbs_checker against a history-queue reference model.
module tb_prbs_checker;

  localparam int N      = 7;
  localparam int TAP    = 6;
  localparam int LOCK_C = 32;
  localparam int LOSS_C = 8;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             emu_clk;
  logic             rst, clk_en, din, clr;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] err_count, bit_count;

  int checks = 0;
  int errors = 0;

  prbs_checker #(
    .N(N), .TAP(TAP), .LOCK_COUNT(LOCK_C), .LOSS_COUNT(LOSS_C), .CNT_W(CNT_W)
  ) dut (
    .emu_clk   (emu_clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .in        (din),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  // Reference model: last N reference bits, oldest first. The prediction is
  // the recurrence s[k] = s[k-N] ^ s[k-TAP] evaluated on that history.
  bit hist[$];
  int mode;        // 0 seeding, 1 verifying, 2 locked
  int n_seed, n_match, n_miss;
  int m_err, m_bits;
  bit m_locked, m_pulse;

  // Stimulus generator: PRBS7 from seed 7'h01, emitted MSB first.
  bit gen_q[$] = '{0, 0, 0, 0, 0, 0, 1};

  function automatic bit gen_next();
    bit b;
    b = gen_q[0];
    gen_q.push_back(gen_q[0] ^ gen_q[1]);
    void'(gen_q.pop_front());
    return b;
  endfunction

  function automatic int ones();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  function automatic void push_hist(bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  function automatic void model(bit r, bit en, bit d, bit c);
    bit p, bv, er;
    bv = 0; er = 0;
    if (r) begin
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(1'b0);
      mode = 0; n_seed = 0; n_match = 0; n_miss = 0;
      m_err = 0; m_bits = 0; m_locked = 0; m_pulse = 0;
      return;
    end
    if (en) begin
      p = hist[0] ^ hist[N-TAP];
      if (mode == 0) begin
        push_hist(d);
        n_seed++;
        if (n_seed == N) begin
          n_seed = 0;
          if (ones() != 0) begin mode = 1; n_match = 0; end
        end
      end else if (mode == 1) begin
        if (d == p) begin
          push_hist(p);
          n_match++;
          if (n_match == LOCK_C) begin mode = 2; n_miss = 0; end
        end else begin
          push_hist(d);
          mode = 0; n_seed = 1;
        end
      end else begin
        push_hist(p);
        bv = 1;
        if (d != p) begin
          er = 1;
          n_miss++;
          if (n_miss == LOSS_C) begin mode = 0; n_seed = 0; end
        end else n_miss = 0;
      end
    end
    if (c) begin
      m_err = 0; m_bits = 0; m_pulse = 0;
    end else begin
      m_pulse = er;
      if (bv && m_bits < CMAX) m_bits++;
      if (er && m_err < CMAX) m_err++;
    end
    m_locked = (mode == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit d, input bit c);
    @(negedge emu_clk);
    rst = r; clk_en = en; din = d; clr = c;
    model(r, en, d, c);
    @(posedge emu_clk);
    #1;
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("bit_count", 32'(bit_count), 32'(m_bits));
  endtask

  // Feeds a clean stream from an unlocked state and returns the enabled bits consumed.
  task automatic run_until_lock(input bit sparse, output int nbits);
    bit en;
    nbits = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      en = sparse ? (cyc % 3 == 0) : 1'b1;
      step(0, en, en ? gen_next() : 1'b0, 0);
      if (en) nbits++;
      if (locked) break;
    end
    chk("lock_reached", {31'd0, locked}, 32'd1);
  endtask

  initial begin
    int  nb;
    bit  seen_lock;
    bit  en, fl;
    rst = 1; clk_en = 0; din = 0; clr = 0;

    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_errcnt", 32'(err_count), 32'd0);

    run_until_lock(0, nb);
    chk("lock_bits_clean", nb, N + LOCK_C);
    for (int i = 0; i < 50; i++) step(0, 1, gen_next(), 0);
    chk("clean_errcnt", 32'(err_count), 32'd0);
    chk("clean_bitcnt", 32'(bit_count), 32'd50);

    step(0, 1, gen_next() ^ 1'b1, 0);
    chk("flip1_pulse", {31'd0, err_pulse}, 32'd1);
    chk("flip1_errcnt", 32'(err_count), 32'd1);
    chk("flip1_locked", {31'd0, locked}, 32'd1);
    step(0, 1, gen_next(), 0);
    chk("flip1_pulse_off", {31'd0, err_pulse}, 32'd0);
    chk("flip1_bitcnt", 32'(bit_count), 32'd52);

    step(0, 1, gen_next(), 1);
    for (int i = 0; i < LOSS_C; i++) begin
      step(0, 1, gen_next() ^ 1'b1, 0);
      if (i == LOSS_C - 2) chk("loss_held_7", {31'd0, locked}, 32'd1);
    end
    chk("loss_errcnt", 32'(err_count), 32'd8);
    chk("loss_locked", {31'd0, locked}, 32'd0);
    run_until_lock(0, nb);
    chk("relock_bits", nb, N + LOCK_C);

    // Reset in the middle of lock, then a full relock from scratch.
    step(1, 1, 0, 0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_bitcnt", 32'(bit_count), 32'd0);
    run_until_lock(1, nb);
    chk("sparse_lock_bits", nb, N + LOCK_C);

    // Clear coincident with an error: cleared, not counted, lock kept.
    for (int i = 0; i < 5; i++) step(0, 1, gen_next(), 0);
    step(0, 1, gen_next() ^ 1'b1, 1);
    chk("clr_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("clr_err_errcnt", 32'(err_count), 32'd0);
    chk("clr_err_bitcnt", 32'(bit_count), 32'd0);
    chk("clr_err_locked", {31'd0, locked}, 32'd1);

    // Saturation of both counters.
    for (int i = 0; i < 260; i++) step(0, 1, gen_next(), 0);
    chk("sat_bitcnt", 32'(bit_count), CMAX);
    for (int i = 0; i < 520; i++) step(0, 1, gen_next() ^ 1'(i % 2), 0);
    chk("sat_errcnt", 32'(err_count), CMAX);
    chk("sat_locked", {31'd0, locked}, 32'd1);

    // Randomized traffic: sparse enables, occasional errors and clears.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      step(0, en, en ? (gen_next() ^ fl) : 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    // Constant zero never locks.
    step(1, 0, 0, 0);
    seen_lock = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, 0, 0);
      seen_lock |= locked;
    end
    chk("zero_never_lock", {31'd0, seen_lock}, 32'd0);
    chk("zero_errcnt", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
